// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: write side, read side, flush and status.
// The slave modport is the FIFO itself; the master modport is the producer/consumer side.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  wr_ovf;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  rd_udf;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  full, almost_full, wr_ovf, rd_data, rd_valid, empty, almost_empty, rd_udf, count
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output full, almost_full, wr_ovf, rd_data, rd_valid, empty, almost_empty, rd_udf, count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, overflow/underflow
// pulses, synchronous flush and a standard (registered) or first-word-fall-through read port.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned READ_MODE  = 0
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus_io
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  localparam cnt_t CntFull = cnt_t'(DEPTH);
  localparam cnt_t CntAf   = cnt_t'(DEPTH - AF_LEVEL);
  localparam cnt_t CntAe   = cnt_t'(AE_LEVEL);
  localparam cnt_t CntOne  = cnt_t'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic wr_ovf_q, wr_ovf_d;
  logic rd_udf_q, rd_udf_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // Acceptance uses pre-edge flags; flush masks both sides and suppresses the error pulses.
  assign wr_acc = bus_io.wr_en & ~full & ~bus_io.flush;
  assign rd_acc = bus_io.rd_en & ~empty & ~bus_io.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ovf_d = bus_io.wr_en & full & ~bus_io.flush;
    rd_udf_d = bus_io.rd_en & empty & ~bus_io.flush;
    if (bus_io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ovf_q <= wr_ovf_d;
      rd_udf_q <= rd_udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus_io.wr_data;
  end

  assign bus_io.count        = count_q;
  assign bus_io.full         = full;
  assign bus_io.empty        = empty;
  assign bus_io.almost_full  = (count_q >= CntAf);
  assign bus_io.almost_empty = (count_q <= CntAe);
  assign bus_io.wr_ovf       = wr_ovf_q;
  assign bus_io.rd_udf       = rd_udf_q;

  if (READ_MODE == 1) begin : g_fwft
    assign bus_io.rd_data  = mem_q[rd_ptr_q];
    assign bus_io.rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus_io.rd_data  = rd_data_q;
    assign bus_io.rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: queue-based scoreboard against a standard-mode instance,
// plus a directed check of a first-word-fall-through instance.
module tb_fifo_sync_param;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [7:0] model_q [$];
  logic [7:0] last_rd;

  fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b0 ();
  fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b1 ();

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(2), .AE_LEVEL(2), .READ_MODE(0)
  ) u_dut_std (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (b0)
  );

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(2), .AE_LEVEL(2), .READ_MODE(1)
  ) u_dut_fwft (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Check every standard-instance status output against the model occupancy.
  task automatic check_std_status(input logic exp_ovf, input logic exp_udf,
                                  input logic exp_valid);
    int c;
    c = model_q.size();
    check_eq("count", 32'(b0.count), 32'(c));
    check_eq("full", 32'(b0.full), 32'(c == 16));
    check_eq("empty", 32'(b0.empty), 32'(c == 0));
    check_eq("almost_full", 32'(b0.almost_full), 32'(c >= 14));
    check_eq("almost_empty", 32'(b0.almost_empty), 32'(c <= 2));
    check_eq("wr_ovf", 32'(b0.wr_ovf), 32'(exp_ovf));
    check_eq("rd_udf", 32'(b0.rd_udf), 32'(exp_udf));
    check_eq("rd_valid", 32'(b0.rd_valid), 32'(exp_valid));
    check_eq("rd_data", 32'(b0.rd_data), 32'(last_rd));
  endtask

  // One clock of stimulus on the standard instance; called at posedge+1.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd, input logic fl);
    logic m_full, m_empty, racc, wacc, e_ovf, e_udf;
    m_full  = (model_q.size() == 16);
    m_empty = (model_q.size() == 0);
    wacc  = wr & ~m_full & ~fl;
    racc  = rd & ~m_empty & ~fl;
    e_ovf = wr & m_full & ~fl;
    e_udf = rd & m_empty & ~fl;
    b0.wr_en   = wr;
    b0.wr_data = wd;
    b0.rd_en   = rd;
    b0.flush   = fl;
    if (fl) begin
      model_q.delete();
    end else begin
      if (racc) last_rd = model_q.pop_front();
      if (wacc) model_q.push_back(wd);
    end
    @(posedge clk);
    #1;
    b0.wr_en = 1'b0;
    b0.rd_en = 1'b0;
    b0.flush = 1'b0;
    check_std_status(e_ovf, e_udf, racc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_rd  = 8'h00;
    rst_n    = 1'b0;
    b0.flush = 1'b0; b0.wr_en = 1'b0; b0.wr_data = '0; b0.rd_en = 1'b0;
    b1.flush = 1'b0; b1.wr_en = 1'b0; b1.wr_data = '0; b1.rd_en = 1'b0;
    #1;
    check_std_status(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap with ordering preserved.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);  // full: read wins, write overflows
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);  // empty: write wins, read underflows
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a concurrent write, then a clean write/read.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    b0.wr_en   = 1'b1;
    b0.wr_data = 8'hEE;
    #3;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    last_rd = 8'h00;
    check_std_status(1'b0, 1'b0, 1'b0);
    b0.wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end

    // First-word-fall-through instance.
    check_eq("fwft_reset_valid", 32'(b1.rd_valid), 32'(0));
    check_eq("fwft_reset_empty", 32'(b1.empty), 32'(1));
    b1.wr_en = 1'b1; b1.wr_data = 8'h11;
    @(posedge clk); #1;
    b1.wr_en = 1'b0;
    check_eq("fwft_first_valid", 32'(b1.rd_valid), 32'(1));
    check_eq("fwft_first_data", 32'(b1.rd_data), 32'h11);
    b1.wr_en = 1'b1; b1.wr_data = 8'h22;
    @(posedge clk); #1;
    b1.wr_en = 1'b0;
    check_eq("fwft_head_hold", 32'(b1.rd_data), 32'h11);
    check_eq("fwft_count2", 32'(b1.count), 32'(2));
    b1.rd_en = 1'b1;
    @(posedge clk); #1;
    b1.rd_en = 1'b0;
    check_eq("fwft_pop_data", 32'(b1.rd_data), 32'h22);
    check_eq("fwft_pop_valid", 32'(b1.rd_valid), 32'(1));
    b1.rd_en = 1'b1;
    @(posedge clk); #1;
    check_eq("fwft_drained_valid", 32'(b1.rd_valid), 32'(0));
    check_eq("fwft_drained_empty", 32'(b1.empty), 32'(1));
    @(posedge clk); #1;
    b1.rd_en = 1'b0;
    check_eq("fwft_udf", 32'(b1.rd_udf), 32'(1));
    @(posedge clk); #1;
    check_eq("fwft_udf_clear", 32'(b1.rd_udf), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
